branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Resolution-side companion to the branch predictor.
- Records each predicted branch at fetch in an in-order outstanding-branch queue and compares the prediction with the actual outcome when execute resolves the branch.
- Drives the predictor's taken/not_taken training pulses with the branch PC.
- On a mispredict, raises a one-cycle flush with the corrected PC, then holds fetch off for a fixed recovery window.

Parameters:
- DEPTH, 4, outstanding-branch queue entries (power of 2, 2..8)
- RECOVER_CYCLES, 2, cycles push_ready stays low after a flush (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- push_valid  in  1  fetch has a branch to record
- push_pc  in  16  branch PC (lc3b_word)
- push_pred_taken  in  1  predictor's direction for that branch
- push_pred_target  in  16  predicted target (used only if pred taken)
- push_ready  out  1  queue can accept a push this cycle
- resolve_valid  in  1  oldest outstanding branch resolved in execute
- resolve_taken  in  1  actual direction
- resolve_target  in  16  actual target
- taken  out  1  one-cycle train-taken pulse to predictor
- not_taken  out  1  one-cycle train-not-taken pulse
- upd_address  out  16  PC of the trained branch, valid with taken/not_taken
- flush  out  1  one-cycle mispredict flush
- redirect_pc  out  16  corrected fetch PC, valid with flush
- queue_count  out  $clog2(DEPTH)+1  outstanding entries
- underflow_err  out  1  sticky: resolve_valid seen with empty queue
- branch_count  out  16  resolved branches, saturating
- mispredict_count  out  16  mispredicts, saturating

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except push_ready; queue empty; state RUN.
  - push_ready follows the combinational rule below, so it is 1 in RUN with an empty queue.
- Queue: circular buffer of entries {pc, pred_taken, pred_target}.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is tracked separately (0..DEPTH).
- push_ready = (state==RUN) && (count<DEPTH). Evaluated from registered state only, with no same-cycle bypass from a pop.
- Push accepted on an edge where push_valid && push_ready; push_valid otherwise ignored.
- Resolve at edge N when resolve_valid && count>0: pop the head entry and compare.
  - mispredict = (pred_taken != resolve_taken) || (resolve_taken && pred_target != resolve_target).
- Outputs registered, valid in cycle N+1 for exactly one cycle:
  - taken = resolve_taken and not_taken = ~resolve_taken; exactly one is high per resolve.
  - upd_address = head pc.
  - branch_count increments, saturating at 16'hFFFF.
  - On mispredict: flush=1, redirect_pc = resolve_taken ? resolve_target : pc+2 (16-bit wrap), mispredict_count increments (saturating).
- Mispredict at edge N: the whole queue is cleared at the same edge (count=0, pointers reset), since all remaining entries are younger. A push in the same cycle is dropped.
- Correct prediction with push in the same cycle: both occur, and count stays unchanged.
- resolve_valid with count==0: no pop, no pulses, no counter changes; underflow_err set sticky until reset.
- State machine:
  - RUN: normal operation. A mispredict moves to RECOVER with recover counter = RECOVER_CYCLES.
  - RECOVER: push_ready=0; counter decrements each cycle; returns to RUN the cycle after it reaches 1.
  - resolve_valid in RECOVER is treated as underflow, since the queue is empty.
- taken/not_taken/flush are low in every cycle not following a valid resolve.
- Reset mid-operation: the queue is discarded immediately and pending pulses are suppressed.

Decomposition:
- lc3b_types gains:
  - typedef br_entry_t {lc3b_word pc; logic pred_taken; lc3b_word pred_target;}
  - localparam BR_PC_INCR = 16'd2
  - enum br_resolve_state_t {BR_RUN, BR_RECOVER}
- One sub-module: br_queue (parameterised circular FIFO of br_entry_t with push, pop, clear, count, full/empty).
- Compare, FSM and stat counters stay in branch_resolver.

Test Plan:
- Push pc=0x0010 pred_taken=1 target=0x0040; resolve taken, target 0x0040 -> next cycle taken=1, upd_address=0x0010, flush=0, branch_count=1.
- Push pc=0x0020 pred_taken=0; resolve taken, target 0x0100 -> next cycle taken=1, flush=1, redirect_pc=0x0100, mispredict_count=1; push_ready=0 for exactly 2 cycles, then 1.
- Push pc=0x0030 pred_taken=1 target=0x0050; resolve taken, target 0x0060 -> flush=1, redirect_pc=0x0060.
- Push pc=0x0044 pred_taken=1; resolve not taken -> not_taken=1, flush=1, redirect_pc=0x0046.
- Fill 4 entries (push_ready=0 at count=4), resolve oldest correct while pushing -> push refused that cycle; next cycle count=3 and push_ready=1. Then 8 more push/resolve pairs verify in-order PCs across pointer wrap.
- With 3 entries queued, mispredict on the head while push_valid=1 -> count=0 next cycle and the push is dropped. A further resolve_valid with the queue empty -> underflow_err=1, no pulses. Assert rst_n=0 mid-stream -> all outputs clear asynchronously.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: queue entry layout, resolver states
// and the saturating counter helper.
package branch_resolver_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    logic     pred_taken;
    lc3b_word pred_target;
  } br_entry_t;

  localparam lc3b_word BR_PC_INCR = 16'd2;

  typedef enum logic {
    BR_RUN     = 1'b0,
    BR_RECOVER = 1'b1
  } br_resolve_state_t;

  function automatic lc3b_word sat_inc(input lc3b_word v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/branch_resolver_br_queue.sv
// In-order circular queue of outstanding predicted branches.
// Clear wins over push/pop; push and pop in the same cycle keep the count.
module branch_resolver_br_queue
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  br_entry_t              entry_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output br_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  br_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted branches in order, trains the predictor and flushes
// fetch on a mispredict, then holds fetch off for a recovery window.
//
// state      | meaning
// BR_RUN     | normal operation, pushes accepted while the queue has room
// BR_RECOVER | post-flush window, push_ready held low for RECOVER_CYCLES
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid,
  input  logic [15:0]            push_pc,
  input  logic                   push_pred_taken,
  input  logic [15:0]            push_pred_target,
  output logic                   push_ready,
  input  logic                   resolve_valid,
  input  logic                   resolve_taken,
  input  logic [15:0]            resolve_target,
  output logic                   taken,
  output logic                   not_taken,
  output logic [15:0]            upd_address,
  output logic                   flush,
  output logic [15:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   underflow_err,
  output logic [15:0]            branch_count,
  output logic [15:0]            mispredict_count
);

  localparam int RW = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES + 1);

  br_resolve_state_t state_q, state_d;
  logic [RW-1:0]     rcnt_q, rcnt_d;

  logic     taken_q, taken_d;
  logic     not_taken_q, not_taken_d;
  logic     flush_q, flush_d;
  lc3b_word upd_q, upd_d;
  lc3b_word redir_q, redir_d;
  lc3b_word bcnt_q, bcnt_d;
  lc3b_word mcnt_q, mcnt_d;
  logic     uf_q, uf_d;

  br_entry_t q_head, q_entry;
  logic      q_push, q_pop, q_clear, q_full, q_empty;
  logic      resolve_fire, mispred;

  assign push_ready = (state_q == BR_RUN) && !q_full;

  assign q_entry = '{pc: push_pc, pred_taken: push_pred_taken, pred_target: push_pred_target};

  assign resolve_fire = resolve_valid && !q_empty;
  assign mispred      = resolve_fire &&
                        ((q_head.pred_taken != resolve_taken) ||
                         (resolve_taken && (q_head.pred_target != resolve_target)));

  // A mispredict squashes every younger entry, including one pushed this cycle.
  assign q_push  = push_valid && push_ready && !mispred;
  assign q_pop   = resolve_fire && !mispred;
  assign q_clear = mispred;

  branch_resolver_br_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (q_push),
    .entry_i (q_entry),
    .pop_i   (q_pop),
    .clear_i (q_clear),
    .head_o  (q_head),
    .count_o (queue_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      BR_RUN: begin
        if (mispred) begin
          state_d = BR_RECOVER;
          rcnt_d  = RW'(RECOVER_CYCLES);
        end
      end
      BR_RECOVER: begin
        rcnt_d = rcnt_q - RW'(1);
        if (rcnt_q <= RW'(1)) state_d = BR_RUN;
      end
      default: state_d = BR_RUN;
    endcase
  end

  always_comb begin
    taken_d     = 1'b0;
    not_taken_d = 1'b0;
    flush_d     = 1'b0;
    upd_d       = upd_q;
    redir_d     = redir_q;
    bcnt_d      = bcnt_q;
    mcnt_d      = mcnt_q;
    uf_d        = uf_q;
    if (resolve_fire) begin
      taken_d     = resolve_taken;
      not_taken_d = !resolve_taken;
      upd_d       = q_head.pc;
      bcnt_d      = sat_inc(bcnt_q);
      if (mispred) begin
        flush_d = 1'b1;
        redir_d = resolve_taken ? resolve_target : q_head.pc + BR_PC_INCR;
        mcnt_d  = sat_inc(mcnt_q);
      end
    end else if (resolve_valid) begin
      uf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BR_RUN;
      rcnt_q      <= '0;
      taken_q     <= 1'b0;
      not_taken_q <= 1'b0;
      flush_q     <= 1'b0;
      upd_q       <= '0;
      redir_q     <= '0;
      bcnt_q      <= '0;
      mcnt_q      <= '0;
      uf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      taken_q     <= taken_d;
      not_taken_q <= not_taken_d;
      flush_q     <= flush_d;
      upd_q       <= upd_d;
      redir_q     <= redir_d;
      bcnt_q      <= bcnt_d;
      mcnt_q      <= mcnt_d;
      uf_q        <= uf_d;
    end
  end

  assign taken            = taken_q;
  assign not_taken        = not_taken_q;
  assign flush            = flush_q;
  assign upd_address      = upd_q;
  assign redirect_pc      = redir_q;
  assign branch_count     = bcnt_q;
  assign mispredict_count = mcnt_q;
  assign underflow_err    = uf_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed and random checks of branch_resolver against a queue-based model.
module tb_branch_resolver;

  localparam int DEPTH   = 4;
  localparam int RECOVER = 2;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_valid, push_pred_taken;
  logic [15:0]   push_pc, push_pred_target;
  logic          push_ready;
  logic          resolve_valid, resolve_taken;
  logic [15:0]   resolve_target;
  logic          taken, not_taken, flush, underflow_err;
  logic [15:0]   upd_address, redirect_pc, branch_count, mispredict_count;
  logic [CW-1:0] queue_count;

  branch_resolver #(.DEPTH(DEPTH), .RECOVER_CYCLES(RECOVER)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_valid       (push_valid),
    .push_pc          (push_pc),
    .push_pred_taken  (push_pred_taken),
    .push_pred_target (push_pred_target),
    .push_ready       (push_ready),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_target   (resolve_target),
    .taken            (taken),
    .not_taken        (not_taken),
    .upd_address      (upd_address),
    .flush            (flush),
    .redirect_pc      (redirect_pc),
    .queue_count      (queue_count),
    .underflow_err    (underflow_err),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        pt;
    logic [15:0] tg;
  } m_ent_t;

  m_ent_t      mq[$];
  int          rec_left;
  logic [15:0] m_bc, m_mc, e_upd, e_redir;
  logic        m_uf, e_taken, e_nt, e_flush;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rec_left = 0;
    m_bc = '0; m_mc = '0; m_uf = 1'b0;
    e_taken = 1'b0; e_nt = 1'b0; e_flush = 1'b0;
  endtask

  // Applies the rules to the inputs present at the edge just taken.
  task automatic model_edge();
    logic   ready, mis;
    m_ent_t e;
    ready   = (rec_left == 0) && (mq.size() < DEPTH);
    mis     = 1'b0;
    e_taken = 1'b0; e_nt = 1'b0; e_flush = 1'b0;
    if (rec_left > 0) rec_left--;
    if (resolve_valid) begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        e_taken = resolve_taken;
        e_nt    = !resolve_taken;
        e_upd   = e.pc;
        if (m_bc != 16'hFFFF) m_bc++;
        mis = (e.pt != resolve_taken) || (resolve_taken && e.tg != resolve_target);
        if (mis) begin
          e_flush = 1'b1;
          e_redir = resolve_taken ? resolve_target : e.pc + 16'd2;
          if (m_mc != 16'hFFFF) m_mc++;
          mq.delete();
          rec_left = RECOVER;
        end
      end else begin
        m_uf = 1'b1;
      end
    end
    if (push_valid && ready && !mis)
      mq.push_back('{pc: push_pc, pt: push_pred_taken, tg: push_pred_target});
  endtask

  task automatic check_all();
    chk("push_ready", push_ready, (rec_left == 0) && (mq.size() < DEPTH));
    chk("taken", taken, e_taken);
    chk("not_taken", not_taken, e_nt);
    chk("flush", flush, e_flush);
    chk("queue_count", queue_count, mq.size());
    chk("underflow_err", underflow_err, m_uf);
    chk("branch_count", branch_count, m_bc);
    chk("mispredict_count", mispredict_count, m_mc);
    if (e_taken || e_nt) chk("upd_address", upd_address, e_upd);
    if (e_flush) chk("redirect_pc", redirect_pc, e_redir);
  endtask

  task automatic cycle(input logic pv, input logic [15:0] ppc, input logic ppt,
                       input logic [15:0] ptg, input logic rv, input logic rt,
                       input logic [15:0] rtg);
    push_valid = pv; push_pc = ppc; push_pred_taken = ppt; push_pred_target = ptg;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  // Push a new branch while resolving the head exactly as it was predicted.
  task automatic push_and_resolve_ok(input logic [15:0] pc);
    cycle(1'b1, pc, 1'b1, pc + 16'h0100, 1'b1, mq[0].pt, mq[0].tg);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0; push_pred_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    idle();

    // correct taken prediction
    cycle(1'b1, 16'h0010, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0040);
    chk("tp1_upd", upd_address, 16'h0010);
    chk("tp1_bc", branch_count, 16'd1);

    // direction mispredict, then 2-cycle recovery
    cycle(1'b1, 16'h0020, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0100);
    chk("tp2_redirect", redirect_pc, 16'h0100);
    chk("tp2_mc", mispredict_count, 16'd1);
    idle();
    chk("tp2_ready_low", push_ready, 1'b0);
    idle();
    chk("tp2_ready_back", push_ready, 1'b1);

    // target mispredict
    cycle(1'b1, 16'h0030, 1'b1, 16'h0050, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0060);
    chk("tp3_redirect", redirect_pc, 16'h0060);
    idle(); idle();

    // predicted taken, actually not taken: fall-through redirect
    cycle(1'b1, 16'h0044, 1'b1, 16'h0080, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("tp4_redirect", redirect_pc, 16'h0046);
    chk("tp4_nt", not_taken, 1'b1);
    idle(); idle();

    // fall-through at the top of the address space wraps to 0
    cycle(1'b1, 16'hFFFE, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("wrap_redirect", redirect_pc, 16'h0000);
    idle(); idle();

    // fill, resolve-while-full, then in-order across pointer wrap
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 16'h0100 + 16'(4 * i), 1'(i % 2), 16'h0300 + 16'(i), 1'b0, 1'b0, 16'h0);
    chk("full_ready", push_ready, 1'b0);
    push_and_resolve_ok(16'h0200);
    chk("full_push_refused_count", queue_count, CW'(DEPTH - 1));
    chk("full_ready_after_pop", push_ready, 1'b1);
    for (int i = 0; i < 8; i++) push_and_resolve_ok(16'h0400 + 16'(2 * i));

    // mispredict on head with 3 queued and a push pending
    cycle(1'b1, 16'h0500, 1'b0, 16'h0, 1'b1, !mq[0].pt, 16'h0600);
    chk("clear_count", queue_count, '0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0);
    chk("underflow_set", underflow_err, 1'b1);
    chk("underflow_no_pulse", taken, 1'b0);
    idle(); idle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic        pv, pt, rv, rt;
      logic [15:0] pc, tg, rtg;
      pv = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      pc = 16'($urandom) & 16'hFFFE;
      tg = 16'($urandom) & 16'hFFFE;
      rv = ($urandom_range(0, 9) < 4);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt = mq[0].pt; rtg = mq[0].tg;
      end else begin
        rt = 1'($urandom_range(0, 1)); rtg = 16'($urandom) & 16'hFFFE;
      end
      cycle(pv, pc, pt, tg, rv, rt, rtg);
    end

    // asynchronous reset with a pulse pending
    idle(); idle(); idle();
    cycle(1'b1, 16'h0700, 1'b1, 16'h0710, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 16'h0702, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_target = 16'h0710;
    push_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_taken", taken, 1'b0);
    chk("rst_count", queue_count, '0);
    check_all();
    resolve_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    idle();
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    chk("post_rst_underflow", underflow_err, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
